// File: rtl/adder_pkg.sv
// adder_pkg: shared types and constants for the adder datapath.
//   seq_state_e : sequencer states (idle, loaded, then one state per completed add step)
//   SEL_*       : Y-operand select codes driven on bsel
package adder_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoaded,
    StAddB,
    StAddC,
    StAddD
  } seq_state_e;

  localparam logic [1:0] SEL_B    = 2'b00;
  localparam logic [1:0] SEL_C    = 2'b01;
  localparam logic [1:0] SEL_D    = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

endpackage

// File: rtl/adder_dp_seq.sv
// adder_dp_seq: control sequencer for adder_datapath.
// Walks the fixed A+B, +C, +D, publish order. It flags any out-of-order select as a protocol
// error and abandons the run.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   load_i     : any operand load this cycle (restarts the run, has top priority)
//   asel_i     : X-operand select as seen by the datapath
//   bsel_i     : Y-operand select as seen by the datapath
//   oe_i       : output_enable
//   acc_clr_o  : clear the accumulator
//   add_en_o   : accumulator takes the adder result
//   publish_o  : copy the accumulator to sum_out
//   proto_err_o: sticky protocol error, cleared only by a load or reset
module adder_dp_seq
  import adder_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       asel_i,
  input  logic [1:0] bsel_i,
  input  logic       oe_i,
  output logic       acc_clr_o,
  output logic       add_en_o,
  output logic       publish_o,
  output logic       proto_err_o
);

  seq_state_e state_q, state_d;
  logic       err_q, err_d;
  logic       sel_ab, sel_c, sel_d;

  // The only legal (asel,bsel) pairs, one per add step.
  assign sel_ab = asel_i & (bsel_i == SEL_B);
  assign sel_c  = ~asel_i & (bsel_i == SEL_C);
  assign sel_d  = ~asel_i & (bsel_i == SEL_D);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Holding the select of the step just taken is a legal wait; anything else aborts.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    if (load_i) begin
      state_d = StLoaded;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle:   ;
        StLoaded: if (sel_ab) state_d = StAddB;
        StAddB: begin
          if (sel_c) begin
            state_d = StAddC;
          end else if (!sel_ab) begin
            state_d = StIdle;
            err_d   = 1'b1;
          end
        end
        StAddC: begin
          if (sel_d) begin
            state_d = StAddD;
          end else if (!sel_c) begin
            state_d = StIdle;
            err_d   = 1'b1;
          end
        end
        StAddD: begin
          if (oe_i) begin
            state_d = StIdle;
          end else if (!sel_d) begin
            state_d = StIdle;
            err_d   = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    acc_clr_o = load_i;
    add_en_o  = 1'b0;
    publish_o = 1'b0;
    if (!load_i) begin
      unique case (state_q)
        StLoaded: add_en_o  = sel_ab;
        StAddB:   add_en_o  = sel_c;
        StAddC:   add_en_o  = sel_d;
        StAddD:   publish_o = oe_i;
        default:  ;
      endcase
    end
  end

  assign proto_err_o = err_q;

endmodule

// File: rtl/adder_datapath.sv
// adder_datapath: four operand registers, an operand mux and a WIDTH+2 bit accumulator.
// The adder_dp_seq sequencer drives it through A+B+C+D and then publishes the result.
// Optional feature macro: ADDER_DP_SAT_EN. It clamps the published result to 2^WIDTH-1
// and adds the sat output.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   aload/bload/cload/dload: capture a_in/b_in/c_in/d_in
//   asel                  : X operand, 1 = A register, 0 = accumulator
//   bsel                  : Y operand, SEL_B/SEL_C/SEL_D/SEL_ZERO
//   output_enable         : publish the accumulator (only honoured after the D step)
//   sum_out               : registered result
//   sum_valid             : one-cycle pulse when sum_out is updated
//   proto_err             : sticky control-sequence error
//   sat                   : saturation flag, present only with ADDER_DP_SAT_EN
module adder_datapath
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             aload,
  input  logic             bload,
  input  logic             cload,
  input  logic             dload,
  input  logic             asel,
  input  logic [1:0]       bsel,
  input  logic             output_enable,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] c_in,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH+1:0] sum_out,
  output logic             sum_valid,
  output logic             proto_err
`ifdef ADDER_DP_SAT_EN
  ,
  output logic             sat
`endif
);

  localparam int unsigned AccW = WIDTH + 2;

  logic [WIDTH-1:0] a_q, b_q, c_q, d_q;
  logic [AccW-1:0]  acc_q, sum_q, x_op, y_op, add_res, pub_val;
  logic             valid_q;
  logic             acc_clr, add_en, publish;

  adder_dp_seq u_seq (
    .clk        (clk),
    .rst        (rst),
    .load_i     (aload | bload | cload | dload),
    .asel_i     (asel),
    .bsel_i     (bsel),
    .oe_i       (output_enable),
    .acc_clr_o  (acc_clr),
    .add_en_o   (add_en),
    .publish_o  (publish),
    .proto_err_o(proto_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      d_q <= '0;
    end else begin
      if (aload) a_q <= a_in;
      if (bload) b_q <= b_in;
      if (cload) c_q <= c_in;
      if (dload) d_q <= d_in;
    end
  end

  // Operands are zero-extended to the accumulator width, so no carry is lost.
  always_comb begin
    x_op = asel ? {2'b00, a_q} : acc_q;
    y_op = '0;
    unique case (bsel)
      SEL_B:    y_op = {2'b00, b_q};
      SEL_C:    y_op = {2'b00, c_q};
      SEL_D:    y_op = {2'b00, d_q};
      SEL_ZERO: y_op = '0;
      default:  y_op = '0;
    endcase
    add_res = x_op + y_op;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (acc_clr) begin
      acc_q <= '0;
    end else if (add_en) begin
      acc_q <= add_res;
    end
  end

`ifdef ADDER_DP_SAT_EN
  localparam logic [AccW-1:0] MaxVal = {2'b00, {WIDTH{1'b1}}};
  logic over, sat_q;
  assign over    = acc_q > MaxVal;
  assign pub_val = over ? MaxVal : acc_q;

  // sat is only meaningful alongside sum_valid, so it is a pulse as well.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sat_q <= 1'b0;
    else     sat_q <= publish & over;
  end
  assign sat = sat_q;
`else
  assign pub_val = acc_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= publish;
      if (publish) sum_q <= pub_val;
    end
  end

  assign sum_out   = sum_q;
  assign sum_valid = valid_q;

endmodule

// File: tb/tb_adder_datapath.sv
module tb_adder_datapath;

  localparam int W    = 8;
  localparam int OW   = W + 2;
  localparam int MaxV = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          aload = 1'b0, bload = 1'b0, cload = 1'b0, dload = 1'b0;
  logic          asel = 1'b0;
  logic [1:0]    bsel = 2'b11;
  logic          output_enable = 1'b0;
  logic [W-1:0]  a_in = '0, b_in = '0, c_in = '0, d_in = '0;
  logic [OW-1:0] sum_out;
  logic          sum_valid, proto_err;
`ifdef ADDER_DP_SAT_EN
  logic          sat;
`endif

  int checks = 0, failures = 0;
  int n_valid = 0, last_sum = 0, last_sat = 0;

  // Reference model: the run is "number of adds done so far" (-1 when no run is open).
  // Legal select to advance from step s is want[s]; repeating the previous one is a wait.
  int want[3] = '{4, 1, 2};  // asel*4 + bsel: (1,B), (0,C), (0,D)
  int m_reg[4];
  int m_acc = 0, m_out = 0, m_stage = -1;
  bit m_valid = 0, m_err = 0, m_sat = 0;

  always #5 clk = ~clk;

  adder_datapath #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .aload        (aload),
    .bload        (bload),
    .cload        (cload),
    .dload        (dload),
    .asel         (asel),
    .bsel         (bsel),
    .output_enable(output_enable),
    .a_in         (a_in),
    .b_in         (b_in),
    .c_in         (c_in),
    .d_in         (d_in),
    .sum_out      (sum_out),
    .sum_valid    (sum_valid),
    .proto_err    (proto_err)
`ifdef ADDER_DP_SAT_EN
    ,
    .sat          (sat)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int sel;
    m_valid = 0;
    m_sat   = 0;
    sel     = (asel ? 4 : 0) + int'(bsel);
    if (rst) begin
      for (int i = 0; i < 4; i++) m_reg[i] = 0;
      m_acc = 0; m_out = 0; m_err = 0; m_stage = -1;
    end else if (aload | bload | cload | dload) begin
      if (aload) m_reg[0] = int'(a_in);
      if (bload) m_reg[1] = int'(b_in);
      if (cload) m_reg[2] = int'(c_in);
      if (dload) m_reg[3] = int'(d_in);
      m_acc = 0; m_err = 0; m_stage = 0;
    end else if (m_stage >= 0) begin
      if (m_stage == 3 && output_enable) begin
`ifdef ADDER_DP_SAT_EN
        m_sat = (m_acc > MaxV);
        m_out = m_sat ? MaxV : m_acc;
`else
        m_out = m_acc;
`endif
        m_valid = 1;
        m_stage = -1;
      end else if (m_stage < 3 && sel == want[m_stage]) begin
        m_acc = (m_stage == 0) ? m_reg[0] + m_reg[1] : m_acc + m_reg[m_stage + 1];
        m_stage++;
      end else if (m_stage > 0 && sel == want[m_stage - 1]) begin
        // waiting on the step just taken
      end else if (m_stage > 0) begin
        m_err   = 1;
        m_stage = -1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    check("sum_out", int'(sum_out), m_out);
    check("sum_valid", int'(sum_valid), int'(m_valid));
    check("proto_err", int'(proto_err), int'(m_err));
`ifdef ADDER_DP_SAT_EN
    check("sat", int'(sat), int'(m_sat));
`endif
    if (sum_valid) begin
      n_valid++;
      last_sum = int'(sum_out);
`ifdef ADDER_DP_SAT_EN
      last_sat = int'(sat);
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_one(input int idx, input int v);
    case (idx)
      0: begin aload = 1; a_in = v[W-1:0]; end
      1: begin bload = 1; b_in = v[W-1:0]; end
      2: begin cload = 1; c_in = v[W-1:0]; end
      default: begin dload = 1; d_in = v[W-1:0]; end
    endcase
    tick(1);
    aload = 0; bload = 0; cload = 0; dload = 0;
  endtask

  task automatic load_all(input int a, input int b, input int c, input int d);
    a_in = a[W-1:0]; b_in = b[W-1:0]; c_in = c[W-1:0]; d_in = d[W-1:0];
    aload = 1; bload = 1; cload = 1; dload = 1;
    tick(1);
    aload = 0; bload = 0; cload = 0; dload = 0;
  endtask

  task automatic step(input bit as, input logic [1:0] bs, input int n);
    asel = as; bsel = bs;
    tick(n);
  endtask

  task automatic publish();
    output_enable = 1;
    tick(1);
    output_enable = 0; asel = 0; bsel = 2'b11;
    tick(2);
  endtask

  task automatic run(input int a, input int b, input int c, input int d, input int hold);
    load_all(a, b, c, d);
    step(1, 2'b00, hold);
    step(0, 2'b01, hold);
    step(0, 2'b10, hold);
    publish();
  endtask

  initial begin
    int v0;
    tick(3);
    check("reset_sum_out", int'(sum_out), 0);
    check("reset_sum_valid", int'(sum_valid), 0);
    check("reset_proto_err", int'(proto_err), 0);
    rst = 0;
    tick(1);

    // Basic run
    v0 = n_valid;
    run(10, 20, 30, 40, 1);
    check("basic_sum", last_sum, 100);
    check("basic_model", m_out, 100);
    check("basic_pulses", n_valid - v0, 1);
    check("basic_err", int'(proto_err), 0);

    // All-ones operands: carry into the extra accumulator bits
    v0 = n_valid;
    run(255, 255, 255, 255, 1);
    check("max_pulses", n_valid - v0, 1);
`ifdef ADDER_DP_SAT_EN
    check("max_sum_sat", last_sum, 255);
    check("max_sat_flag", last_sat, 1);
`else
    check("max_sum_full", last_sum, 1020);
    check("max_model", m_out, 1020);
`endif

    // Out-of-order select after A+B
    load_all(1, 2, 3, 4);
    step(1, 2'b00, 1);
    step(0, 2'b10, 1);
    check("err_set", int'(proto_err), 1);
    v0 = n_valid;
    output_enable = 1;
    tick(3);
    output_enable = 0;
    check("err_no_valid", n_valid - v0, 0);
    check("err_sticky", int'(proto_err), 1);
    load_one(0, 5);
    check("err_clr_on_load", int'(proto_err), 0);

    // Each select held three cycles must not re-add
    v0 = n_valid;
    run(10, 20, 30, 40, 3);
    check("hold_sum", last_sum, 100);
    check("hold_pulses", n_valid - v0, 1);

    // Reset in the middle of a run, then output_enable held in idle
    load_all(10, 20, 30, 40);
    step(1, 2'b00, 1);
    step(0, 2'b01, 1);
    v0 = n_valid;
    rst = 1;
    tick(1);
    rst = 0;
    check("rst_sum_out", int'(sum_out), 0);
    check("rst_sum_valid", int'(sum_valid), 0);
    check("rst_proto_err", int'(proto_err), 0);
    asel = 0; bsel = 2'b10; output_enable = 1;
    tick(4);
    output_enable = 0; bsel = 2'b11;
    tick(1);
    check("rst_idle_no_valid", n_valid - v0, 0);

    // Reload mid-run restarts with the new operands
    load_all(10, 20, 30, 40);
    step(1, 2'b00, 1);
    step(0, 2'b01, 1);
    load_one(0, 1);
    load_one(1, 2);
    load_one(2, 3);
    load_one(3, 4);
    v0 = n_valid;
    step(1, 2'b00, 1);
    step(0, 2'b01, 1);
    step(0, 2'b10, 1);
    publish();
    check("reload_sum", last_sum, 10);
    check("reload_model", m_out, 10);
    check("reload_pulses", n_valid - v0, 1);

    // Randomized traffic, biased toward legal sequences so runs complete
    for (int i = 0; i < 3000; i++) begin
      int code;
      rst   = ($urandom_range(0, 299) == 0);
      aload = ($urandom_range(0, 19) == 0);
      bload = ($urandom_range(0, 19) == 0);
      cload = ($urandom_range(0, 19) == 0);
      dload = ($urandom_range(0, 19) == 0);
      a_in  = W'($urandom); b_in = W'($urandom);
      c_in  = W'($urandom); d_in = W'($urandom);
      if (m_stage >= 0 && m_stage < 3 && $urandom_range(0, 3) != 0) code = want[m_stage];
      else if (m_stage == 3 && $urandom_range(0, 2) != 0)            code = 2;
      else                                                            code = $urandom_range(0, 7);
      asel = code[2];
      bsel = code[1:0];
      output_enable = ($urandom_range(0, 3) == 0);
      tick(1);
    end
    rst = 0; aload = 0; bload = 0; cload = 0; dload = 0; output_enable = 0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_datapath.md
ADDER_DATAPATH -- requirements
Module: adder_datapath

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand width in bits.
REQ-002 SHALL have ports (clock and reset first):
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- aload  input  1  capture a_in into A register
- bload  input  1  capture b_in into B register
- cload  input  1  capture c_in into C register
- dload  input  1  capture d_in into D register
- asel  input  1  adder X-operand select: 1 = A register, 0 = accumulator
- bsel  input  2  adder Y-operand select: 00 = B, 01 = C, 10 = D, 11 = zero
- output_enable  input  1  publish accumulator to sum_out
- a_in, b_in, c_in, d_in  input  WIDTH each  operand data
- sum_out  output  WIDTH+2  registered result
- sum_valid  output  1  one-cycle pulse, sum_out updated
- proto_err  output  1  sticky control-sequence error
- sat  output  1  saturation flag, only with ADDER_DP_SAT_EN
REQ-003 Reset SHALL be rst, asynchronous, active-high; clock SHALL be clk.

Function
REQ-004 Each xload high at an edge SHALL capture its input into its own register; loads are independent.
REQ-005 Accumulator SHALL be WIDTH+2 bits; an add step SHALL compute ACC <= X + Y, with the operand zero-extended and no carry lost.
REQ-006 Sequencer states SHALL be IDLE, LOADED, ADD_B, ADD_C, ADD_D.
REQ-007 From any state, any xload high SHALL go to LOADED, clear ACC, and clear proto_err; load SHALL win over every other simultaneous input.
REQ-008 LOADED: loads low with (asel,bsel)=(1,00) SHALL do ACC<=A+B and go to ADD_B; every other combination SHALL be ignored.
REQ-009 ADD_B: (0,01) SHALL do ACC<=ACC+C and go to ADD_C; (1,00) held SHALL hold with no re-add; anything else SHALL set proto_err and go to IDLE.
REQ-010 ADD_C: (0,10) SHALL do ACC<=ACC+D and go to ADD_D; (0,01) held SHALL hold; anything else SHALL set proto_err and go to IDLE.
REQ-011 ADD_D: output_enable high SHALL register sum_out<=ACC, pulse sum_valid the next cycle for exactly 1 cycle, and go to IDLE; (0,10) with output_enable low SHALL hold; anything else SHALL set proto_err and go to IDLE.
REQ-012 In IDLE, output_enable, asel and bsel SHALL be ignored, including output_enable held high; sum_out SHALL retain its value.
REQ-013 Latency SHALL be 1 cycle from output_enable sampled in ADD_D to sum_valid high.
REQ-014 proto_err SHALL remain set until the next load or reset; sum_valid SHALL never assert for an errored run.

Reset
REQ-015 Reset SHALL clear A, B, C, D, ACC, sum_out, sum_valid, proto_err and sat, and set state IDLE; reset mid-run SHALL abandon the run with no sum_valid.

Configuration
REQ-016 With ADDER_DP_SAT_EN defined: on publish, if ACC > 2^WIDTH-1, sum_out SHALL be 2^WIDTH-1 (upper bits zero) and sat=1 for the sum_valid cycle; otherwise sat=0.
REQ-017 Without ADDER_DP_SAT_EN: sum_out SHALL carry the full WIDTH+2 result, and the sat port SHALL be absent.

Structure
REQ-018 Package adder_pkg SHALL hold the sequencer state enum and the bsel codes SEL_B, SEL_C, SEL_D, SEL_ZERO.
REQ-019 Sub-module adder_dp_seq SHALL implement the sequencer and emit add_en and publish strobes; the top SHALL hold the registers, mux and adder.

Verification
REQ-020 WIDTH=8, load A=10, B=20, C=30, D=40, then (1,00), (0,01), (0,10), output_enable -> sum_out=100, sum_valid high 1 cycle, proto_err=0.
REQ-021 All operands 255, full sequence -> sum_out=1020 without the macro; with ADDER_DP_SAT_EN, sum_out=255 and sat=1.
REQ-022 After (1,00) in ADD_B, apply (0,10) -> proto_err=1, state IDLE, no sum_valid; a following load -> proto_err=0.
REQ-023 Each select step held 3 cycles -> same result 100, no double add.
REQ-024 rst pulsed in ADD_C -> all outputs 0, no sum_valid; output_enable held high in IDLE afterwards -> no sum_valid.
REQ-025 Reload A=1 in ADD_C, then complete with B=2, C=3, D=4 -> sum_out=10.
